rf_multi_master_bridge: RTL and testbench

- Parametrised successor of the single-master HMC register-file access port.
- Arbitrates NUM_MASTERS independent requesters (bench sequencers, BIST, link-training FSM) onto one HMC register-file bus using round-robin.
- Issues one access at a time, applies a completion timeout, and returns read data, invalid-address status and timeout status to the granted master.
- Sits between the requesters and the HMC controller register file.

---
 rtl/rf_bridge_pkg.sv | 25 ++
 rtl/rf_rr_arbiter.sv | 33 +++
 rtl/rf_multi_master_bridge.sv | 192 +++++++++++++++++++
 tb/tb_rf_multi_master_bridge.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_bridge_pkg.sv
// Shared types and width helpers for the multi-master register-file bridge.
package rf_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } rf_state_e;

  // Status returned to the granted master alongside its read data.
  typedef struct packed {
    logic invalid;
    logic timeout;
  } rf_resp_t;

  function automatic int grant_idx_w(input int num_masters);
    return (num_masters > 1) ? $clog2(num_masters) : 1;
  endfunction

  function automatic int timeout_cnt_w(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/rf_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1 with wrap-around.
module rf_rr_arbiter
  import rf_bridge_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IW          = grant_idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          last_grant,
  input  logic                   en,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IW-1:0]          gnt_idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = IW'((int'(last_grant) + i) % NUM_MASTERS);
      if (en && !found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/rf_multi_master_bridge.sv
// Round-robin bridge from NUM_MASTERS requesters onto one HMC register-file bus,
// one access at a time with a completion timeout.
module rf_multi_master_bridge
  import rf_bridge_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int HMC_RF_WWIDTH  = 64,
  parameter int HMC_RF_RWIDTH  = 64,
  parameter int HMC_RF_AWIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                   clk,
  input  logic                                   res_n,
  input  logic [NUM_MASTERS-1:0]                 m_req,
  input  logic [NUM_MASTERS-1:0]                 m_we,
  input  logic [NUM_MASTERS*HMC_RF_AWIDTH-1:0]   m_addr,
  input  logic [NUM_MASTERS*HMC_RF_WWIDTH-1:0]   m_wdata,
  output logic [NUM_MASTERS-1:0]                 m_ack,
  output logic [HMC_RF_RWIDTH-1:0]               m_rdata,
  output logic                                   m_invalid,
  output logic                                   m_timeout,
  output logic [HMC_RF_AWIDTH-1:0]               rf_address,
  output logic [HMC_RF_WWIDTH-1:0]               rf_write_data,
  input  logic [HMC_RF_RWIDTH-1:0]               rf_read_data,
  input  logic                                   rf_access_complete,
  input  logic                                   rf_invalid_address,
  output logic                                   rf_read_enable,
  output logic                                   rf_write_enable,
  output logic                                   stray_complete
);

  localparam int IW = grant_idx_w(NUM_MASTERS);
  localparam int CW = timeout_cnt_w(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_STROBE = ST_STROBE;
  localparam logic [1:0] S_WAIT   = ST_WAIT;
  localparam logic [1:0] S_RESP   = ST_RESP;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]               state_q, state_d;
  logic [IW-1:0]            grant_q, grant_d;
  logic [IW-1:0]            last_grant_q, last_grant_d;
  logic                     we_q, we_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [HMC_RF_AWIDTH-1:0] rf_address_q, rf_address_d;
  logic [HMC_RF_WWIDTH-1:0] rf_write_data_q, rf_write_data_d;
  logic                     rf_read_enable_q, rf_read_enable_d;
  logic                     rf_write_enable_q, rf_write_enable_d;
  logic [NUM_MASTERS-1:0]   m_ack_q, m_ack_d;
  logic [HMC_RF_RWIDTH-1:0] m_rdata_q, m_rdata_d;
  rf_resp_t                 resp_q, resp_d;
  logic                     stray_q, stray_d;

  logic [NUM_MASTERS-1:0]   arb_gnt;
  logic [IW-1:0]            arb_idx;
  logic                     arb_vld;
  logic                     sel_we;
  logic [HMC_RF_AWIDTH-1:0] sel_addr;
  logic [HMC_RF_WWIDTH-1:0] sel_wdata;
  logic [NUM_MASTERS-1:0]   grant_onehot;

  rf_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IW          (IW)
  ) u_arb (
    .req        (m_req),
    .last_grant (last_grant_q),
    .en         (state_q == S_IDLE),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx)
  );

  assign arb_vld = |arb_gnt;

  // Slice out the winning master's fields and expand the latched grant to one-hot.
  always_comb begin
    sel_we       = 1'b0;
    sel_addr     = '0;
    sel_wdata    = '0;
    grant_onehot = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (arb_idx == IW'(i)) begin
        sel_we    = m_we[i];
        sel_addr  = m_addr[i*HMC_RF_AWIDTH +: HMC_RF_AWIDTH];
        sel_wdata = m_wdata[i*HMC_RF_WWIDTH +: HMC_RF_WWIDTH];
      end
      grant_onehot[i] = (grant_q == IW'(i));
    end
  end

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    last_grant_d      = last_grant_q;
    we_d              = we_q;
    cnt_d             = cnt_q;
    rf_address_d      = rf_address_q;
    rf_write_data_d   = rf_write_data_q;
    rf_read_enable_d  = 1'b0;
    rf_write_enable_d = 1'b0;
    m_ack_d           = '0;
    m_rdata_d         = '0;
    resp_d            = '0;
    // Completions are only expected in WAIT; late ones after a timeout land here too.
    stray_d           = rf_access_complete && (state_q != S_WAIT);

    case (state_q)
      S_IDLE: begin
        if (arb_vld) begin
          grant_d           = arb_idx;
          last_grant_d      = arb_idx;
          we_d              = sel_we;
          rf_address_d      = sel_addr;
          rf_write_data_d   = sel_wdata;
          rf_write_enable_d = sel_we;
          rf_read_enable_d  = !sel_we;
          state_d           = S_STROBE;
        end
      end
      S_STROBE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rf_access_complete) begin
          m_ack_d        = grant_onehot;
          m_rdata_d      = we_q ? '0 : rf_read_data;
          resp_d.invalid = rf_invalid_address;
          state_d        = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          m_ack_d        = grant_onehot;
          resp_d.timeout = 1'b1;
          state_d        = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A reset mid-access simply drops it; the register file is never told.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q           <= S_IDLE;
      grant_q           <= '0;
      last_grant_q      <= IW'(NUM_MASTERS - 1);
      we_q              <= 1'b0;
      cnt_q             <= '0;
      rf_address_q      <= '0;
      rf_write_data_q   <= '0;
      rf_read_enable_q  <= 1'b0;
      rf_write_enable_q <= 1'b0;
      m_ack_q           <= '0;
      m_rdata_q         <= '0;
      resp_q            <= '0;
      stray_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      grant_q           <= grant_d;
      last_grant_q      <= last_grant_d;
      we_q              <= we_d;
      cnt_q             <= cnt_d;
      rf_address_q      <= rf_address_d;
      rf_write_data_q   <= rf_write_data_d;
      rf_read_enable_q  <= rf_read_enable_d;
      rf_write_enable_q <= rf_write_enable_d;
      m_ack_q           <= m_ack_d;
      m_rdata_q         <= m_rdata_d;
      resp_q            <= resp_d;
      stray_q           <= stray_d;
    end
  end

  assign m_ack           = m_ack_q;
  assign m_rdata         = m_rdata_q;
  assign m_invalid       = resp_q.invalid;
  assign m_timeout       = resp_q.timeout;
  assign rf_address      = rf_address_q;
  assign rf_write_data   = rf_write_data_q;
  assign rf_read_enable  = rf_read_enable_q;
  assign rf_write_enable = rf_write_enable_q;
  assign stray_complete  = stray_q;

endmodule

// File: tb/tb_rf_multi_master_bridge.sv
// Bench for rf_multi_master_bridge: directed scenarios with literal expectations, then
// randomized masters/slave checked every cycle against a transaction-level reference.
module tb_rf_multi_master_bridge;

  localparam int N = 4;
  localparam int T = 8;

  logic          clk;
  logic          res_n;
  logic [3:0]    m_req;
  logic [3:0]    m_we;
  logic [15:0]   m_addr;
  logic [255:0]  m_wdata;
  logic [3:0]    m_ack;
  logic [63:0]   m_rdata;
  logic          m_invalid;
  logic          m_timeout;
  logic [3:0]    rf_address;
  logic [63:0]   rf_write_data;
  logic [63:0]   rf_read_data;
  logic          rf_access_complete;
  logic          rf_invalid_address;
  logic          rf_read_enable;
  logic          rf_write_enable;
  logic          stray_complete;

  rf_multi_master_bridge #(
    .NUM_MASTERS    (N),
    .HMC_RF_WWIDTH  (64),
    .HMC_RF_RWIDTH  (64),
    .HMC_RF_AWIDTH  (4),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk                (clk),
    .res_n              (res_n),
    .m_req              (m_req),
    .m_we               (m_we),
    .m_addr             (m_addr),
    .m_wdata            (m_wdata),
    .m_ack              (m_ack),
    .m_rdata            (m_rdata),
    .m_invalid          (m_invalid),
    .m_timeout          (m_timeout),
    .rf_address         (rf_address),
    .rf_write_data      (rf_write_data),
    .rf_read_data       (rf_read_data),
    .rf_access_complete (rf_access_complete),
    .rf_invalid_address (rf_invalid_address),
    .rf_read_enable     (rf_read_enable),
    .rf_write_enable    (rf_write_enable),
    .stray_complete     (stray_complete)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Inputs as sampled by the DUT at the upcoming edge.
  bit          s_rst;
  logic [3:0]  s_req, s_we;
  logic [15:0] s_addr;
  logic [255:0] s_wdata;
  bit          s_cmp, s_inv;
  logic [63:0] s_rdata;

  // Reference: one transaction in flight, tracked by its age since the grant edge.
  bit          md_busy, md_resp, md_we;
  int          md_age, md_win, md_last;
  logic [3:0]  e_ack, e_addr;
  logic [63:0] e_rdata, e_wdata;
  bit          e_inv, e_to, e_re, e_we, e_stray;

  function void model_update();
    bit found;
    int c;
    e_ack = '0; e_rdata = '0; e_inv = 0; e_to = 0; e_re = 0; e_we = 0; e_stray = 0;
    if (!s_rst) begin
      md_busy = 0; md_resp = 0; md_age = 0; md_last = N - 1;
      e_addr = '0; e_wdata = '0;
      return;
    end
    e_stray = s_cmp && !(md_busy && !md_resp && md_age >= 2);
    if (md_resp) begin
      md_resp = 0;
      md_busy = 0;
    end else if (md_busy) begin
      if (md_age == 1) begin
        md_age = 2;
      end else if (s_cmp || (md_age - 1 == T)) begin
        md_resp = 1;
        e_ack   = 4'b0001 << md_win;
        if (s_cmp) begin
          e_rdata = md_we ? 64'h0 : s_rdata;
          e_inv   = s_inv;
        end else begin
          e_to = 1;
        end
      end else begin
        md_age++;
      end
    end else begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (md_last + k) % N;
        if (!found && s_req[c]) begin
          found   = 1;
          md_busy = 1;
          md_age  = 1;
          md_win  = c;
          md_last = c;
          md_we   = s_we[c];
          e_addr  = s_addr[c*4 +: 4];
          e_wdata = s_wdata[c*64 +: 64];
          e_re    = !s_we[c];
          e_we    = s_we[c];
        end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    chk("m_ack", 64'(m_ack), 64'(e_ack));
    chk("m_rdata", m_rdata, e_rdata);
    chk("m_invalid", 64'(m_invalid), 64'(e_inv));
    chk("m_timeout", 64'(m_timeout), 64'(e_to));
    chk("rf_read_enable", 64'(rf_read_enable), 64'(e_re));
    chk("rf_write_enable", 64'(rf_write_enable), 64'(e_we));
    chk("stray_complete", 64'(stray_complete), 64'(e_stray));
    if (md_busy) begin
      chk("rf_address", 64'(rf_address), 64'(e_addr));
      chk("rf_write_data", rf_write_data, e_wdata);
    end
  endtask

  task automatic step();
    s_rst = res_n; s_req = m_req; s_we = m_we; s_addr = m_addr; s_wdata = m_wdata;
    s_cmp = rf_access_complete; s_rdata = rf_read_data; s_inv = rf_invalid_address;
    @(posedge clk);
    model_update();
    #1;
    compare();
    cyc++;
  endtask

  // One complete access by a single master; cw = WAIT cycle carrying the completion (0 = never).
  task automatic do_access(input int idx, input bit we, input logic [3:0] a, input logic [63:0] wd,
                           input int cw, input logic [63:0] rd, input bit inv,
                           output logic [3:0] ack_o, output logic [63:0] rd_o, output bit inv_o,
                           output bit to_o, output bit re_o, output bit we_o,
                           output logic [3:0] a_o, output logic [63:0] wd_o, output int lat_o);
    bit got;
    int k;
    m_we[idx] = we;
    m_addr[idx*4 +: 4] = a;
    m_wdata[idx*64 +: 64] = wd;
    m_req[idx] = 1'b1;
    step();
    re_o = rf_read_enable; we_o = rf_write_enable; a_o = rf_address; wd_o = rf_write_data;
    ack_o = '0; rd_o = '0; inv_o = 0; to_o = 0; lat_o = -1; got = 0;
    rf_access_complete = 1'b0;
    step();
    k = 1;
    while (!got && k <= T + 2) begin
      rf_access_complete = (k == cw);
      rf_read_data = rd;
      rf_invalid_address = inv;
      step();
      if (m_ack != 0) begin
        got = 1; ack_o = m_ack; rd_o = m_rdata; inv_o = m_invalid; to_o = m_timeout; lat_o = k + 2;
      end
      k++;
    end
    chk("ack_within_bound", 64'(got), 64'd1);
    rf_access_complete = 1'b0;
    step();
    m_req[idx] = 1'b0;
  endtask

  initial begin
    logic [3:0]  ack, a;
    logic [63:0] rd, wd;
    bit          inv, to, re, we;
    int          lat;
    int          order[$];
    int          tstamp[$];
    logic [3:0]  drop, relow, cool, drop_mask;
    bit          strobe_last;
    int          tgt_w;
    int          gi;

    res_n = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    rf_read_data = 64'h0; rf_access_complete = 1'b1; rf_invalid_address = 1'b0;
    step();
    step();
    chk("rst_ack", 64'(m_ack), 64'h0);
    chk("rst_stray", 64'(stray_complete), 64'h0);
    chk("rst_rf_address", 64'(rf_address), 64'h0);
    chk("rst_rdata", m_rdata, 64'h0);
    res_n = 1'b1; rf_access_complete = 1'b0;
    step();

    // Single read, master 1, completion in the first WAIT cycle.
    do_access(1, 1'b0, 4'h3, 64'h0, 1, 64'hDEAD_BEEF, 1'b0, ack, rd, inv, to, re, we, a, wd, lat);
    chk("rd_strobe", 64'(re), 64'd1);
    chk("rd_no_wstrobe", 64'(we), 64'd0);
    chk("rd_addr", 64'(a), 64'h3);
    chk("rd_ack", 64'(ack), 64'b0010);
    chk("rd_data", rd, 64'hDEAD_BEEF);
    chk("rd_invalid", 64'(inv), 64'd0);
    chk("rd_latency", 64'(lat), 64'd3);

    // Write to invalid address, master 0.
    do_access(0, 1'b1, 4'hF, 64'h1234, 1, 64'h5555, 1'b1, ack, rd, inv, to, re, we, a, wd, lat);
    chk("wr_strobe", 64'(we), 64'd1);
    chk("wr_no_rstrobe", 64'(re), 64'd0);
    chk("wr_data_out", wd, 64'h1234);
    chk("wr_ack", 64'(ack), 64'b0001);
    chk("wr_invalid", 64'(inv), 64'd1);
    chk("wr_rdata_zero", rd, 64'h0);

    // Timeout, then a late completion.
    do_access(2, 1'b0, 4'h7, 64'h0, 0, 64'hFFFF, 1'b1, ack, rd, inv, to, re, we, a, wd, lat);
    chk("to_ack", 64'(ack), 64'b0100);
    chk("to_flag", 64'(to), 64'd1);
    chk("to_rdata", rd, 64'h0);
    chk("to_invalid", 64'(inv), 64'd0);
    chk("to_latency", 64'(lat), 64'(T + 2));
    step();
    rf_access_complete = 1'b1;
    step();
    chk("late_stray", 64'(stray_complete), 64'd1);
    chk("late_no_ack", 64'(m_ack), 64'h0);
    rf_access_complete = 1'b0;
    step();
    chk("late_stray_gone", 64'(stray_complete), 64'd0);

    // Completion in the final WAIT cycle wins over the timeout.
    do_access(3, 1'b0, 4'h2, 64'h0, T, 64'hCAFE_F00D_1234_5678, 1'b0, ack, rd, inv, to, re, we, a, wd, lat);
    chk("edge_ack", 64'(ack), 64'b1000);
    chk("edge_timeout", 64'(to), 64'd0);
    chk("edge_rdata", rd, 64'hCAFE_F00D_1234_5678);
    chk("edge_latency", 64'(lat), 64'(T + 2));

    // Reset during WAIT.
    m_we[2] = 1'b0; m_addr[8 +: 4] = 4'h5; m_req[2] = 1'b1;
    step();
    step();
    m_we[0] = 1'b1; m_addr[0 +: 4] = 4'h9; m_wdata[0 +: 64] = 64'h77; m_req[0] = 1'b1;
    step();
    res_n = 1'b0; rf_access_complete = 1'b1;
    step();
    chk("midrst_ack", 64'(m_ack), 64'h0);
    chk("midrst_addr", 64'(rf_address), 64'h0);
    chk("midrst_stray", 64'(stray_complete), 64'd0);
    chk("midrst_renable", 64'(rf_read_enable), 64'd0);
    res_n = 1'b1; rf_access_complete = 1'b0;
    step();
    chk("midrst_regrant_we", 64'(rf_write_enable), 64'd1);
    chk("midrst_regrant_addr", 64'(rf_address), 64'h9);

    // Round-robin: all masters request continuously from reset.
    res_n = 1'b0; m_req = '0;
    step();
    res_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_we[i] = 1'($urandom);
      m_addr[i*4 +: 4] = 4'($urandom);
      m_wdata[i*64 +: 64] = {$urandom, $urandom};
    end
    m_req = 4'hF;
    drop = '0; relow = '0; strobe_last = 0;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      step();
      chk("rr_one_strobe", 64'(rf_read_enable & rf_write_enable), 64'd0);
      if (m_ack != 0) begin
        gi = -1;
        for (int i = 0; i < N; i++) if (m_ack[i]) gi = i;
        order.push_back(gi);
        tstamp.push_back(c);
      end
      m_req = m_req | relow;
      relow = '0;
      if (drop != 0) begin
        m_req = m_req & ~drop;
        relow = drop;
        drop  = '0;
      end
      if (m_ack != 0) drop = m_ack;
      rf_access_complete = strobe_last;
      strobe_last = rf_read_enable | rf_write_enable;
      rf_read_data = {$urandom, $urandom};
    end
    chk("rr_count", 64'(order.size()), 64'd5);
    for (int i = 0; i < order.size(); i++) begin
      chk("rr_order", 64'(order[i]), 64'(i % N));
      if (i > 0) chk("rr_interval", 64'(tstamp[i] - tstamp[i-1]), 64'd4);
    end

    // Randomized traffic against the reference.
    drop_mask = drop;
    tgt_w = 1;
    for (int c = 0; c < 4000; c++) begin
      if (!res_n) res_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) res_n = 1'b0;
      m_req = m_req & ~drop_mask;
      cool = drop_mask;
      drop_mask = e_ack;
      for (int i = 0; i < N; i++) begin
        if (!m_req[i]) begin
          m_we[i] = 1'($urandom);
          m_addr[i*4 +: 4] = 4'($urandom);
          m_wdata[i*64 +: 64] = {$urandom, $urandom};
          if (!cool[i] && $urandom_range(0, 3) == 0) m_req[i] = 1'b1;
        end
      end
      if (md_busy && !md_resp && md_age == 1) tgt_w = $urandom_range(1, T + 2);
      if (md_busy && !md_resp && md_age >= 2) rf_access_complete = (md_age - 1 == tgt_w);
      else rf_access_complete = ($urandom_range(0, 11) == 0);
      rf_read_data = {$urandom, $urandom};
      rf_invalid_address = 1'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
